aes_shift_rows_pipe: RTL
========================

// Module: aes_shift_rows_pipe
// PURPOSE
//  Parametrised Rijndael ShiftRows / InvShiftRows stage with valid/ready handshake.
//  Supports block widths of Nb = 4, 6 or 8 columns.
//  Direction (forward or inverse) is selected per transaction.
//  Carries a sideband tag. Full-throughput elastic buffer: main register plus skid register.
//  Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round datapath.
// PARAMETERS
//  NB     4   state columns; legal 4, 6, 8; data width W = 32*NB
//  TAG_W  4   sideband tag width (round number / key slot), passed through unchanged
//  CNT_W  16  width of the completed-block counter
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous, active-high reset
//  i_clear  in   1      synchronous flush of buffered blocks (counter kept)
//  i_valid  in   1      upstream block valid
//  o_ready  out  1      this stage can accept a block
//  i_mode   in   1      0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
//  i_tag    in   TAG_W  sideband tag
//  i_data   in   W      state, column-major; byte k = r+4c at [W-1-8k -: 8]
//  o_valid  out  1      output block valid
//  i_ready  in   1      downstream ready
//  o_data   out  W      shifted state
//  o_tag    out  TAG_W  tag of the block on o_data
//  o_count  out  CNT_W  blocks delivered (o_valid & i_ready), wraps modulo 2^CNT_W
// BEHAVIOUR
//  Row offsets sh(r):
//   - NB = 4 or 6: 0, 1, 2, 3
//   - NB = 8: 0, 1, 3, 4
//  Transform:
//   - Forward: out[r][c] = in[r][(c+sh(r)) mod NB]
//   - Inverse: out[r][c] = in[r][(c-sh(r)) mod NB]
//   - Row 0 is never moved.
//  Transform is combinational on the input side; the result is registered on accept.
//   - Accept = i_valid & o_ready.
//   - Mode is sampled at accept only; changing i_mode while a block is buffered has no effect on it.
//  Latency: 1 cycle (accept in cycle N -> o_valid in N+1 when the buffer was empty).
//  Throughput: 1 block/cycle while i_ready = 1.
//  o_ready = !skid_full (registered; no combinational path from i_ready).
//  Buffer states (2-bit occupancy):
//   - EMPTY: o_valid = 0. Accept -> MAIN.
//   - MAIN: o_valid = 1.
//     - Accept & drain: main is replaced -> MAIN.
//     - Drain only -> EMPTY.
//     - Accept only: block goes to skid -> FULL.
//   - FULL: o_valid = 1, o_ready = 0. On drain, skid moves to main -> MAIN.
//  Ordering is strictly FIFO; no block is dropped or duplicated.
//  Holding rule: o_data/o_tag are stable while o_valid & !i_ready.
//  i_clear: next state EMPTY. Any accept or drain in the same cycle is discarded and o_count is not incremented.
//  rst, which has priority over i_clear, forces:
//   - state EMPTY
//   - o_valid = 0, o_ready = 1
//   - o_data = 0, o_tag = 0, o_count = 0
//  rst mid-transfer loses buffered blocks; this is the intended behaviour.
//  o_count increments by 1 on each delivered block; all-ones + 1 -> 0.
//  Illegal NB values are caught by an elaboration-time $error.
// STRUCTURE
//  Package aes_pkg:
//   - aes_mode_t enum {AES_ENC = 1'b0, AES_DEC = 1'b1}
//   - function shift_off(nb, r)
//   - localparam BYTE_W = 8
//  Sub-module aes_shift_rows_comb: purely combinational, params NB; ports i_data, i_mode, o_data.
//   - Generate loops over r, c; no arithmetic beyond constant mod-NB indexing.
//  Top level holds the main/skid registers, occupancy state and counter.
// TESTING
//  1. NB=4, mode=0, i_data=d42711aee0bf98f1b8b45de51e415230 -> o_data=d4bf5d30e0b452aeb84111f11e2798e5, o_valid one cycle later.
//  2. NB=4, mode=1, i_data=d4bf5d30e0b452aeb84111f11e2798e5 -> o_data=d42711aee0bf98f1b8b45de51e415230 (round trip).
//  3. NB=8, mode=0, byte k = k (00..1f) -> out(2,0)=0e, out(3,0)=13, out(1,7)=01, row 0 unchanged.
//  4. Backpressure: stream tags 1,2,3 with i_ready=0 for 3 cycles -> o_ready falls after 2 accepts; delivery order is tags 1,2,3; o_count=3.
//  5. i_clear while FULL, together with i_valid=1 -> next cycle o_valid=0, o_ready=1, o_count unchanged, the clear-cycle block is not delivered.
//  6. rst during a sustained stream -> next cycle all outputs 0 except o_ready=1; count wraps at CNT_W=2 after 4 deliveries -> 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the Rijndael ShiftRows pipeline stage.
// Supports the 4-, 6- and 8-column block widths.
package aes_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      AES_ENC = 1'b0,
      AES_DEC = 1'b1
   } aes_mode_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_MAIN  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   // Rijndael row offsets: the 8-column variant skips offset 2 on rows 2 and 3.
   function automatic int shift_off(input int nb, input int r);
      if (r == 0) begin
         return 0;
      end else if (nb == 8 && r >= 2) begin
         return r + 1;
      end else begin
         return r;
      end
   endfunction

endpackage

// File: rtl/aes_shift_rows_comb.sv
// Purely combinational ShiftRows / InvShiftRows byte permutation.
// Every output byte is a constant-indexed mux between two input bytes.
module aes_shift_rows_comb
   import aes_pkg::*;
#(
   parameter int NB = 4,
   localparam int W = 32 * NB
)
(
   input  logic [W-1:0] i_data,
   input  logic         i_mode,
   output logic [W-1:0] o_data
);

   logic inv;

   assign inv = (aes_mode_t'(i_mode) == AES_DEC);

   // Byte k = r + 4c lives at [W-1-8k -: 8]; source columns are elaboration constants.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int SH      = shift_off(NB, r);
         localparam int SRC_FWD = (c + SH) % NB;
         localparam int SRC_INV = (c - SH + NB) % NB;
         localparam int DST     = W - 1 - BYTE_W * (r + 4 * c);
         localparam int POS_FWD = W - 1 - BYTE_W * (r + 4 * SRC_FWD);
         localparam int POS_INV = W - 1 - BYTE_W * (r + 4 * SRC_INV);

         assign o_data[DST -: BYTE_W] = inv ? i_data[POS_INV -: BYTE_W]
                                            : i_data[POS_FWD -: BYTE_W];
      end
   end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// ShiftRows / InvShiftRows round stage with a main + skid elastic buffer,
// sideband tag pass-through and a delivered-block counter.
module aes_shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16,
   localparam int W    = 32 * NB
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_mode,
   input  logic [TAG_W-1:0] i_tag,
   input  logic [W-1:0]     i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [W-1:0]     o_data,
   output logic [TAG_W-1:0] o_tag,
   output logic [CNT_W-1:0] o_count
);

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end

   occ_t             state;
   occ_t             state_next;
   logic [W-1:0]     shifted;
   logic [W-1:0]     main_data;
   logic [W-1:0]     skid_data;
   logic [TAG_W-1:0] main_tag;
   logic [TAG_W-1:0] skid_tag;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             drain;
   logic             load_main_new;
   logic             load_main_skid;
   logic             load_skid;

   aes_shift_rows_comb #(.NB(NB)) u_comb (
      .i_data (i_data),
      .i_mode (i_mode),
      .o_data (shifted)
   );

   // o_ready decodes registered state only, so it never depends on i_ready.
   assign o_valid = (state != OCC_EMPTY);
   assign o_ready = (state != OCC_FULL);
   assign accept  = i_valid & o_ready;
   assign drain   = o_valid & i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OCC_EMPTY;
      end else if (i_clear) begin
         state <= OCC_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         OCC_EMPTY: begin
            if (accept) begin
               state_next    = OCC_MAIN;
               load_main_new = 1'b1;
            end
         end
         OCC_MAIN: begin
            if (accept && drain) begin
               load_main_new = 1'b1;
            end else if (drain) begin
               state_next = OCC_EMPTY;
            end else if (accept) begin
               state_next = OCC_FULL;
               load_skid  = 1'b1;
            end
         end
         OCC_FULL: begin
            if (drain) begin
               state_next     = OCC_MAIN;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            state_next = OCC_EMPTY;
         end
      endcase
   end

   // A clear discards the cycle's transfers; stale register contents are harmless once EMPTY.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_data <= '0;
         main_tag  <= '0;
         skid_data <= '0;
         skid_tag  <= '0;
         count     <= '0;
      end else if (!i_clear) begin
         if (load_main_new) begin
            main_data <= shifted;
            main_tag  <= i_tag;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_tag  <= skid_tag;
         end
         if (load_skid) begin
            skid_data <= shifted;
            skid_tag  <= i_tag;
         end
         if (drain) begin
            count <= count + CNT_W'(1);
         end
      end
   end

   assign o_data  = main_data;
   assign o_tag   = main_tag;
   assign o_count = count;

endmodule
